// File: rtl/sd_sample_streamer_pkg.sv
// Shared definitions for the SD sample streamer.
//   - write-side FSM state encoding
//   - ping-pong buffer geometry (two 512-byte banks, 256 samples each)
//   - bank_addr(): forms a buffer address from a bank select and byte offset
package sd_sample_streamer_pkg;

    localparam int BANK_BYTES       = 512;
    localparam int SAMPLES_PER_BANK = 256;
    localparam int RAM_AW           = 10;   // 2 banks x 512 bytes

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_REQ,
        ST_FILL,
        ST_WAIT_FREE,
        ST_DRAIN,
        ST_DONE
    } wr_state_e;

    function automatic logic [RAM_AW-1:0] bank_addr(input logic bank, input logic [8:0] off);
        return {bank, off};
    endfunction

endpackage

// File: rtl/sd_sample_streamer_if.sv
// Block-read bus between the SD card reader and its consumer.
//   master : consumer side (drives trigger/continuous-mode/address, receives bytes)
//   slave  : reader side
//   block_read_card_ready    reader idle, accepts a trigger
//   block_read_trigger       1-cycle read request
//   block_read_continous_mode multi-block mode select
//   block_read_block_addr    block address for the request
//   block_read_data_out      read byte
//   block_read_data_idx      byte index within the block
//   block_read_data_new_flag 1-cycle strobe qualifying data_out/data_idx
interface sd_sample_streamer_if #(
    parameter int ADDR_BITS = 32,
    parameter int IDX_BITS  = 9
);
    logic                 block_read_card_ready;
    logic                 block_read_trigger;
    logic                 block_read_continous_mode;
    logic [ADDR_BITS-1:0] block_read_block_addr;
    logic [7:0]           block_read_data_out;
    logic [IDX_BITS-1:0]  block_read_data_idx;
    logic                 block_read_data_new_flag;

    modport master (
        output block_read_trigger, block_read_continous_mode, block_read_block_addr,
        input  block_read_card_ready, block_read_data_out, block_read_data_idx,
               block_read_data_new_flag
    );

    modport slave (
        input  block_read_trigger, block_read_continous_mode, block_read_block_addr,
        output block_read_card_ready, block_read_data_out, block_read_data_idx,
               block_read_data_new_flag
    );
endinterface

// File: rtl/sd_sample_streamer_ram.sv
// sd_pingpong_ram: simple dual-port RAM holding both ping-pong banks.
//   clk      in  clock
//   we_i     in  write enable
//   waddr_i  in  write address
//   wdata_i  in  write byte
//   raddr_i  in  read address
//   rdata_o  out read byte, registered (1-cycle latency)
// No reset on the array or read register so it maps onto block RAM.
module sd_pingpong_ram
    import sd_sample_streamer_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sd_sample_streamer.sv
// sd_sample_streamer: fetches N consecutive SD blocks into a 2-bank ping-pong
// buffer and serves signed 16-bit little-endian samples on request.
//   clk, rst_n           clock, async active-low reset
//   start_i / stop_i     begin stream (IDLE only) / finish current block then flush
//   start_block_i        first block address, latched on start
//   num_blocks_i         block count, latched on start
//   card_configured_i    SD init complete; start is ignored without it
//   rd                   block-read bus to the SD reader (master side)
//   sample_req_i         next sample wanted
//   sample_out_o         sample, held until the next sample_valid_o
//   sample_valid_o       strobe, 3 cycles after an accepted request
//   underrun_o           strobe with sample_valid_o when no full bank was available
//   busy_o / done_o      stream active / end-of-stream strobe
module sd_sample_streamer
    import sd_sample_streamer_pkg::*;
#(
    parameter int ADDR_BITS = 32,
    parameter int IDX_BITS  = 9,
    parameter int NBLK_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [ADDR_BITS-1:0] start_block_i,
    input  logic [NBLK_BITS-1:0] num_blocks_i,
    input  logic                 card_configured_i,
    sd_sample_streamer_if.master rd,
    input  logic                 sample_req_i,
    output logic [15:0]          sample_out_o,
    output logic                 sample_valid_o,
    output logic                 underrun_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BANK_BYTES - 1);

    // ---------------- write side ----------------
    wr_state_e            state_q;
    logic [ADDR_BITS-1:0] cur_addr_q;
    logic [NBLK_BITS-1:0] blocks_left_q;
    logic                 wr_bank_q;
    logic                 stop_pend_q;
    logic                 busy_q, done_q, trig_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [1:0]           bank_full_q, bank_full_d;

    // ---------------- read side ----------------
    logic                 rd_bank_q;
    logic [7:0]           rd_ptr_q;
    logic [1:0]           rd_pipe_q;   // [0]: LSB on RAM output, [1]: MSB on RAM output
    logic [1:0]           hit_pipe_q;
    logic [7:0]           lsb_q;
    logic [15:0]          sample_q;
    logic                 valid_q, underrun_q;

    logic                 start_acc, ram_we, fill_last, accept, bank_last;
    logic [RAM_AW-1:0]    ram_raddr;
    logic [7:0]           ram_rdata;

    assign start_acc = (state_q == ST_IDLE) && start_i && card_configured_i;
    assign ram_we    = (state_q == ST_FILL) && rd.block_read_data_new_flag;
    assign fill_last = ram_we && (rd.block_read_data_idx == LAST_IDX);

    // A new request is taken only when nothing is in flight; no queueing.
    assign accept    = sample_req_i && busy_q && (rd_pipe_q == 2'b00);
    assign bank_last = rd_pipe_q[0] && hit_pipe_q[0] && (rd_ptr_q == 8'hFF);

    // Byte select follows the pipe: byte 0 is addressed in the accept cycle,
    // byte 1 in the next, so both come out of the sync-read port back to back.
    assign ram_raddr = bank_addr(rd_bank_q, {rd_ptr_q, rd_pipe_q[0]});

    sd_pingpong_ram #(.AW(RAM_AW), .DW(8)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (bank_addr(wr_bank_q, rd.block_read_data_idx)),
        .wdata_i (rd.block_read_data_out),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Writer sets its bank and reader clears its bank; they never coincide.
    always_comb begin
        bank_full_d = bank_full_q;
        if (fill_last) bank_full_d[wr_bank_q] = 1'b1;
        if (bank_last) bank_full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bank_full_q <= 2'b00;
        else        bank_full_q <= bank_full_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cur_addr_q    <= '0;
            blocks_left_q <= '0;
            wr_bank_q     <= 1'b0;
            stop_pend_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            trig_q        <= 1'b0;
            addr_q        <= '0;
        end else begin
            trig_q <= 1'b0;
            done_q <= 1'b0;
            if (state_q != ST_IDLE && stop_i) stop_pend_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    stop_pend_q <= 1'b0;
                    if (start_acc) begin
                        cur_addr_q    <= start_block_i;
                        blocks_left_q <= num_blocks_i;
                        wr_bank_q     <= 1'b0;
                        busy_q        <= 1'b1;
                        state_q       <= (num_blocks_i == '0) ? ST_DONE : ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: if (rd.block_read_card_ready) state_q <= ST_REQ;
                ST_REQ: begin
                    trig_q  <= 1'b1;
                    addr_q  <= cur_addr_q;
                    state_q <= ST_FILL;
                end
                ST_FILL: begin
                    if (fill_last) begin
                        cur_addr_q    <= cur_addr_q + ADDR_BITS'(1);
                        blocks_left_q <= blocks_left_q - NBLK_BITS'(1);
                        // A stop arriving with the last byte still ends the stream here.
                        if (blocks_left_q == NBLK_BITS'(1) || stop_pend_q || stop_i) begin
                            state_q <= ST_DRAIN;
                        end else if (!bank_full_q[~wr_bank_q]) begin
                            wr_bank_q <= ~wr_bank_q;
                            state_q   <= ST_WAIT_RDY;
                        end else begin
                            state_q <= ST_WAIT_FREE;
                        end
                    end
                end
                ST_WAIT_FREE: begin
                    if (!bank_full_q[~wr_bank_q]) begin
                        wr_bank_q <= ~wr_bank_q;
                        state_q   <= ST_WAIT_RDY;
                    end
                end
                ST_DRAIN: if (bank_full_q == 2'b00) state_q <= ST_DONE;
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            rd_pipe_q  <= '0;
            hit_pipe_q <= '0;
            lsb_q      <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            rd_pipe_q  <= {rd_pipe_q[0], accept};
            hit_pipe_q <= {hit_pipe_q[0], accept && bank_full_q[rd_bank_q]};
            valid_q    <= rd_pipe_q[1];
            underrun_q <= rd_pipe_q[1] && !hit_pipe_q[1];
            if (rd_pipe_q[0]) lsb_q <= ram_rdata;
            if (rd_pipe_q[1]) sample_q <= hit_pipe_q[1] ? {ram_rdata, lsb_q} : 16'h0000;
            // Pointers restart with each stream so both sides begin on bank 0.
            if (start_acc) begin
                rd_bank_q <= 1'b0;
                rd_ptr_q  <= '0;
            end else if (rd_pipe_q[0] && hit_pipe_q[0]) begin
                rd_ptr_q <= rd_ptr_q + 8'd1;
                if (rd_ptr_q == 8'hFF) rd_bank_q <= ~rd_bank_q;
            end
        end
    end

    assign rd.block_read_trigger        = trig_q;
    assign rd.block_read_continous_mode = 1'b0;
    assign rd.block_read_block_addr     = addr_q;
    assign sample_out_o   = sample_q;
    assign sample_valid_o = valid_q;
    assign underrun_o     = underrun_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule
